multiplicador_8_bits_seq: RTL and testbench



---
 rtl/multiplicador_pkg.sv | 17 +
 rtl/somador_8_bits.sv | 27 ++
 rtl/multiplicador_8_bits_seq.sv | 106 ++++++++++
 tb/tb_multiplicador_8_bits_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package multiplicador_pkg;

  // Default operand width and iteration-counter width (log2 of the width).
  localparam int LARG_DEF      = 8;
  localparam int LARG_CONT_DEF = 3;

  // Controller states.
  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    CONCLUI = 2'b10
  } estado_t;

endpackage

// File: rtl/somador_8_bits.sv
// Carry-ripple adder, LARG bits plus carry-in, sum and carry-out.
// Latency: combinational, no registers.
// Backpressure: none, the outputs always follow the inputs.
// Ports: a, b operands; cin carry-in; s sum; cout carry-out.
module somador_8_bits #(
  parameter int LARG = 8
) (
  input  logic [LARG-1:0] a,
  input  logic [LARG-1:0] b,
  input  logic            cin,
  output logic [LARG-1:0] s,
  output logic            cout
);

  // c[i] is the carry into bit i; c[LARG] leaves the adder.
  logic [LARG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < LARG; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[LARG];

endmodule

// File: rtl/multiplicador_8_bits_seq.sv
// Unsigned shift-and-add multiplier, LARG x LARG -> 2*LARG, one partial product per clock.
// Latency: start taken at edge k, produto and done valid after edge k+LARG, idle again after k+LARG+1.
// Backpressure: start is only sampled in OCIOSO; requests while busy or done are dropped, not queued.
// Ports: clk, rst (async, active-high); start, a, b request; produto result; busy, done status.
module multiplicador_8_bits_seq
  import multiplicador_pkg::*;
#(
  parameter int LARG      = LARG_DEF,
  parameter int LARG_CONT = LARG_CONT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LARG-1:0]   a,
  input  logic [LARG-1:0]   b,
  output logic [2*LARG-1:0] produto,
  output logic              busy,
  output logic              done
);

  estado_t estado, estado_prox;

  logic [LARG-1:0]      m;      // multiplicand
  logic [LARG-1:0]      acc;    // upper half of the partial product
  logic [LARG-1:0]      q;      // multiplier, shifted out as product bits shift in
  logic [LARG_CONT-1:0] cont;   // iteration count

  logic [LARG-1:0] parcela;
  logic [LARG-1:0] soma;
  logic            cy;
  logic            ultimo;

  // Add the multiplicand only when the current multiplier bit is set.
  assign parcela = q[0] ? m : '0;

  somador_8_bits #(
    .LARG (LARG)
  ) u_somador (
    .a    (acc),
    .b    (parcela),
    .cin  (1'b0),
    .s    (soma),
    .cout (cy)
  );

  assign ultimo = (cont == LARG_CONT'(LARG - 1));

  // Next-state logic.
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (start)  estado_prox = CALCULA;
      CALCULA: if (ultimo) estado_prox = CONCLUI;
      CONCLUI: estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  // State register; busy/done are decoded from the next state so they come
  // straight out of flops and line up exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= OCIOSO;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      estado <= estado_prox;
      busy   <= (estado_prox == CALCULA);
      done   <= (estado_prox == CONCLUI);
    end
  end

  // Datapath. The adder carry is not held in a flop of its own: each step it
  // is shifted straight into acc[LARG-1], so no product bit is ever dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cont    <= '0;
      produto <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (start) begin
            m    <= a;
            q    <= b;
            acc  <= '0;
            cont <= '0;
          end
        end
        CALCULA: begin
          acc  <= {cy, soma[LARG-1:1]};
          q    <= {soma[0], q[LARG-1:1]};
          cont <= cont + 1'b1;
          // Publish the shifted value of this final step directly.
          if (ultimo) begin
            produto <= {cy, soma, q[LARG-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_8_bits_seq.sv
// Self-checking bench for multiplicador_8_bits_seq.
// Expected products are queued when an operation is issued and compared when done pulses.
module tb_multiplicador_8_bits_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic [15:0] produto;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [15:0] esperado[$];
  logic        done_prev = 1'b0;

  always #5 clk = ~clk;

  multiplicador_8_bits_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .produto (produto),
    .busy    (busy),
    .done    (done)
  );

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Output monitor: every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (esperado.size() == 0) confere("spurious_done", 32'(done), 32'd0);
      else                      confere("produto", 32'(produto), 32'(esperado.pop_front()));
      confere("done_width", 32'(done_prev), 32'd0);
    end
    done_prev = done;
  end

  // Check that every queued product was consumed by a done pulse.
  task automatic sem_pendentes(input string tag);
    confere(tag, 32'(esperado.size()), 32'd0);
    esperado.delete();
  endtask

  // One operation: start for one edge, measure latency and busy length,
  // optionally pulse start (with other operands) mid-computation.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit poke);
    int n;
    int busy_cnt;
    int p;
    p = int'(x) * int'(y);
    esperado.push_back(16'(p));
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    busy_cnt = busy ? 1 : 0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      start = poke && (n == 3);
      if (poke && n == 3) begin
        a = 8'd1;
        b = 8'd1;
      end
      if (done) break;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    confere("latency", 32'(n), 32'd8);
    confere("busy_len", 32'(busy_cnt), 32'd8);
    confere("busy_at_done", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    confere("hold", 32'(produto), 32'(p));
    confere("done_after", 32'(done), 32'd0);
    sem_pendentes("missing_done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int m;
    bit seen_done;

    // Reset state.
    #2 rst = 1'b1;
    #1;
    confere("rst_produto", 32'(produto), 32'd0);
    confere("rst_busy", 32'(busy), 32'd0);
    confere("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    confere("idle_busy", 32'(busy), 32'd0);

    run_op(8'd13, 8'd11, 1'b0);   // 143
    run_op(8'd255, 8'd255, 1'b1); // 0xFE01, with a start poked mid-run
    run_op(8'd0, 8'd200, 1'b0);
    run_op(8'd200, 8'd0, 1'b0);

    // Back-to-back with start held: the request seen in CONCLUI is not taken,
    // the following edge (back in OCIOSO) takes it.
    esperado.push_back(16'd63);
    esperado.push_back(16'd15);
    a = 8'd7;
    b = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd3;
    b = 8'd5;
    n = 0;
    seen_done = 1'b0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen_done = 1'b1;
      else if (seen_done && busy) break;
    end
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    confere("b2b_accept", 32'(n), 32'd10);
    m = 0;
    while (m < 40) begin
      @(posedge clk);
      #1;
      m++;
      if (done) break;
    end
    confere("b2b_latency", 32'(m), 32'd8);
    repeat (3) @(posedge clk);
    #1;
    confere("b2b_hold", 32'(produto), 32'd15);
    sem_pendentes("b2b_missing_done");

    // Asynchronous reset after four steps of 100*100: no done, result cleared.
    a = 8'd100;
    b = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    confere("arst_busy", 32'(busy), 32'd0);
    confere("arst_done", 32'(done), 32'd0);
    confere("arst_produto", 32'(produto), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    confere("arst_idle_busy", 32'(busy), 32'd0);
    run_op(8'd100, 8'd100, 1'b0); // 10000

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
